// File: rtl/data_bus_control.sv
// rtl/data_bus_control.sv - zero-wait-state byte-addressed data RAM with size/alignment checking
module data_bus_control #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    output logic        busy,
    output logic        fault,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size_in,
    input  logic [1:0]  size_out,
    input  logic [31:0] addr_in,
    input  logic [31:0] addr_out,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [7:0]    mem [MEM_BYTES];
    logic          ready_q;
    logic          fault_q;

    logic [31:0]   wr_off;
    logic [31:0]   rd_off;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   rdata;

    // Range is checked on the start offset only; natural alignment plus a
    // power-of-two RAM size guarantees the last byte is in range too.
    function automatic logic access_ok(input logic [31:0] off, input logic [1:0] size);
        logic ok;
        ok = 1'b0;
        if (off < MEM_LIMIT) begin
            case (size)
                SIZE_BYTE: ok = 1'b1;
                SIZE_HALF: ok = (off[0] == 1'b0);
                SIZE_WORD: ok = (off[1:0] == 2'b00);
                default:   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign wr_off = addr_in - BASE_ADDR;
    assign rd_off = addr_out - BASE_ADDR;
    assign wr_idx = wr_off[AW-1:0];
    assign rd_idx = rd_off[AW-1:0];
    assign wr_ok  = access_ok(wr_off, size_in);
    assign rd_ok  = access_ok(rd_off, size_out);

    // Gating with rst keeps writes and read data suppressed the instant reset asserts.
    assign wr_en = rst & ready_q & wd & wr_ok;
    assign rd_en = rst & ready_q & rd & rd_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (ready_q) begin
                fault_q <= (wd & ~wr_ok) | (rd & ~rd_ok);
            end
        end
    end

    // RAM has no reset: contents survive rst and start undefined.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data_in[7:0];
            if (size_in != SIZE_BYTE) begin
                mem[wr_idx + AW'(1)] <= data_in[15:8];
            end
            if (size_in == SIZE_WORD) begin
                mem[wr_idx + AW'(2)] <= data_in[23:16];
                mem[wr_idx + AW'(3)] <= data_in[31:24];
            end
        end
    end

    // Combinational read sees pre-edge contents, so a same-cycle write is not visible.
    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (size_out)
                SIZE_BYTE: rdata = {24'h0, mem[rd_idx]};
                SIZE_HALF: rdata = {16'h0, mem[rd_idx + AW'(1)], mem[rd_idx]};
                SIZE_WORD: rdata = {mem[rd_idx + AW'(3)], mem[rd_idx + AW'(2)],
                                    mem[rd_idx + AW'(1)], mem[rd_idx]};
                default:   rdata = 32'h0;
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = 1'b0;
    assign fault    = fault_q;
    assign data_out = rdata;

endmodule

// File: tb/tb_data_bus_control.sv
// tb/tb_data_bus_control.sv - scoreboard bench for data_bus_control
module tb_data_bus_control;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        busy;
    logic        fault;
    logic        wd;
    logic        rd;
    logic [1:0]  size_in;
    logic [1:0]  size_out;
    logic [31:0] addr_in;
    logic [31:0] addr_out;
    logic [31:0] data_in;
    logic [31:0] data_out;

    localparam int SIG_DOUT  = 0;
    localparam int SIG_FAULT = 1;
    localparam int SIG_READY = 2;
    localparam int SIG_BUSY  = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    data_bus_control dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault),
        .wd       (wd),
        .rd       (rd),
        .size_in  (size_in),
        .size_out (size_out),
        .addr_in  (addr_in),
        .addr_out (addr_out),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge and retires every expectation due by now.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].cyc <= cyc) begin
                e = sb[i];
                sb.delete(i);
                case (e.sig)
                    SIG_DOUT:  act = data_out;
                    SIG_FAULT: act = {31'h0, fault};
                    SIG_READY: act = {31'h0, ready};
                    default:   act = {31'h0, busy};
                endcase
                checks++;
                if (e.cyc != cyc || act !== e.exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h",
                             e.name, cyc, e.cyc, act, e.exp);
                end
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int off, input int sig, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = sig;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        wd      = en;
        size_in = s;
        addr_in = a;
        data_in = d;
    endtask

    task automatic set_rd(input logic en, input logic [1:0] s, input logic [31:0] a);
        rd       = en;
        size_out = s;
        addr_out = a;
    endtask

    initial begin
        rst = 1'b0;
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_W, 32'h10);

        tick();
        expect_at(0, SIG_READY, 32'h0, "rst_ready");
        expect_at(0, SIG_FAULT, 32'h0, "rst_fault");
        expect_at(0, SIG_BUSY,  32'h0, "rst_busy");
        expect_at(0, SIG_DOUT,  32'h0, "rst_dout");

        tick();
        rst = 1'b1;
        set_rd(1'b0, SZ_W, 32'h0);
        expect_at(0, SIG_READY, 32'h0, "ready_before_edge");
        expect_at(0, SIG_BUSY,  32'h0, "busy_released");

        tick();
        expect_at(0, SIG_READY, 32'h1, "ready_after_edge");
        expect_at(0, SIG_FAULT, 32'h0, "fault_after_release");
        set_wr(1'b1, SZ_W, 32'h0, 32'h0BAD_F00D);

        tick();
        set_wr(1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF);
        expect_at(1, SIG_FAULT, 32'h0, "wr_word_fault");

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_W, 32'h10);
        expect_at(0, SIG_DOUT, 32'hDEAD_BEEF, "rd_word_10");

        tick();
        set_rd(1'b1, SZ_B, 32'h13);
        expect_at(0, SIG_DOUT, 32'h0000_00DE, "rd_byte_13");

        tick();
        set_rd(1'b1, SZ_H, 32'h12);
        expect_at(0, SIG_DOUT, 32'h0000_DEAD, "rd_half_12");
        expect_at(0, SIG_BUSY, 32'h0, "busy_running");

        tick();
        set_wr(1'b1, SZ_B, 32'h11, 32'hFFFF_FF55);
        set_rd(1'b1, SZ_W, 32'h10);
        expect_at(0, SIG_DOUT, 32'hDEAD_BEEF, "rd_during_write_old");

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        expect_at(0, SIG_DOUT, 32'hDEAD_55EF, "rd_after_byte_write");

        tick();
        set_wr(1'b1, SZ_W, 32'h12, 32'hCAFE_F00D);
        set_rd(1'b0, SZ_W, 32'h0);
        expect_at(0, SIG_DOUT, 32'h0, "dout_rd_idle");
        expect_at(1, SIG_FAULT, 32'h1, "misaligned_wr_fault");

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_W, 32'h10);
        expect_at(0, SIG_DOUT, 32'hDEAD_55EF, "misaligned_wr_no_change");
        expect_at(1, SIG_FAULT, 32'h0, "valid_rd_clears_fault");

        tick();
        set_rd(1'b1, SZ_H, 32'h11);
        expect_at(0, SIG_DOUT, 32'h0, "misaligned_half_dout");
        expect_at(1, SIG_FAULT, 32'h1, "misaligned_half_fault");

        tick();
        set_rd(1'b1, SZ_X, 32'h10);
        expect_at(0, SIG_DOUT, 32'h0, "size11_dout");
        expect_at(1, SIG_FAULT, 32'h1, "size11_fault");

        tick();
        set_rd(1'b0, SZ_W, 32'h0);
        set_wr(1'b1, SZ_W, 32'h1000, 32'h9999_9999);
        expect_at(1, SIG_FAULT, 32'h1, "oor_wr_fault");

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_W, 32'h0);
        expect_at(0, SIG_DOUT, 32'h0BAD_F00D, "oor_wr_no_alias");
        expect_at(1, SIG_FAULT, 32'h0, "rd_0_fault");

        tick();
        set_rd(1'b1, SZ_W, 32'h1000);
        expect_at(0, SIG_DOUT, 32'h0, "oor_rd_dout");
        expect_at(1, SIG_FAULT, 32'h1, "oor_rd_fault");

        tick();
        set_rd(1'b0, SZ_W, 32'h0);
        set_wr(1'b1, SZ_W, 32'hFFC, 32'h1234_5678);

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_W, 32'hFFC);
        expect_at(0, SIG_DOUT, 32'h1234_5678, "rd_top_word");
        expect_at(1, SIG_FAULT, 32'h0, "top_word_fault");

        tick();
        set_rd(1'b0, SZ_W, 32'h0);
        set_wr(1'b1, SZ_W, 32'h20, 32'h1111_1111);

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        set_rd(1'b1, SZ_X, 32'h20);

        // fault is 1 entering this cycle; the reset must clear it without an edge.
        tick();
        set_rd(1'b0, SZ_W, 32'h0);
        set_wr(1'b1, SZ_W, 32'h20, 32'hAAAA_AAAA);
        rst = 1'b0;
        expect_at(0, SIG_READY, 32'h0, "midwrite_rst_ready");
        expect_at(0, SIG_FAULT, 32'h0, "midwrite_rst_fault");

        tick();
        set_wr(1'b0, SZ_W, 32'h0, 32'h0);
        expect_at(0, SIG_READY, 32'h0, "rst_held_ready");

        tick();
        rst = 1'b1;
        expect_at(0, SIG_READY, 32'h0, "rerelease_ready");

        tick();
        set_rd(1'b1, SZ_W, 32'h20);
        expect_at(0, SIG_READY, 32'h1, "ready_again");
        expect_at(0, SIG_DOUT, 32'h1111_1111, "rst_suppressed_write");
        expect_at(1, SIG_FAULT, 32'h0, "post_rst_fault");

        tick();
        set_rd(1'b0, SZ_W, 32'h0);
        tick();
        tick();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_control.md
DATA_BUS_CONTROL -- requirements
Module: data_bus_control

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, first byte address of the data RAM.
REQ-002 The block SHALL have parameter MEM_BYTES, default 4096, RAM size in bytes, a power of two and at least 4.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 ready  output  1  controller accepts accesses.
REQ-007 busy  output  1  access in progress (wait state).
REQ-008 fault  output  1  registered flag: last sampled access was rejected.
REQ-009 wd  input  1  write request, level-sensitive.
REQ-010 rd  input  1  read request, level-sensitive.
REQ-011 size_in  input  2  write size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-012 size_out  input  2  read size, same encoding as size_in.
REQ-013 addr_in  input  32  write byte address.
REQ-014 addr_out  input  32  read byte address.
REQ-015 data_in  input  32  write data, right-aligned.
REQ-016 data_out  output  32  read data, right-aligned.

Function
REQ-017 The block SHALL hold MEM_BYTES bytes of internal RAM, byte-addressed, little-endian.
REQ-018 An access SHALL be valid only when offset = addr - BASE_ADDR is below MEM_BYTES.
REQ-019 A valid access SHALL be naturally aligned: halfword with offset[0]=0, word with offset[1:0]=00; size 11 is never valid.
REQ-020 A write SHALL commit at the rising edge where ready=1, wd=1 and the access is valid.
REQ-021 Byte writes SHALL use data_in[7:0], halfword writes data_in[15:0], word writes data_in[31:0].
REQ-022 A write SHALL leave all untouched bytes unchanged.
REQ-023 A read SHALL be combinational from addr_out/size_out when rd=1, ready=1 and the access is valid.
REQ-024 Read data SHALL be zero-extended; sign extension is done by the core.
REQ-025 data_out SHALL be 32'h0 when rd=0, ready=0, or the read is invalid.
REQ-026 wd and rd SHALL be independent; both in one cycle perform the read (pre-write data) and the write.
REQ-027 A read of the address being written in the same cycle SHALL return the old contents.
REQ-028 busy SHALL be constant 0 (zero-wait-state implementation).
REQ-029 fault SHALL be updated at each rising edge while ready=1.
REQ-030 fault SHALL be set to 1 when (wd=1 and the write is invalid) or (rd=1 and the read is invalid), else 0.
REQ-031 An invalid write SHALL modify no RAM byte.
REQ-032 Address arithmetic SHALL be 32-bit unsigned; addresses below BASE_ADDR wrap to a large offset and are therefore invalid.

Reset
REQ-033 While rst=0: ready=0, fault=0, data_out=0, no writes, asynchronously.
REQ-034 ready SHALL rise at the first rising clk edge after rst returns to 1.
REQ-035 RAM contents SHALL be undefined at power-up and preserved across reset.
REQ-036 Reset asserted in a write cycle SHALL suppress that write.

Verification
REQ-037 Reset, release -> ready=0 until first edge, then 1; busy=0 and fault=0 throughout.
REQ-038 Word write 0xDEADBEEF @0x10, then word read @0x10 -> 0xDEADBEEF; byte read @0x13 -> 0x000000DE; half read @0x12 -> 0x0000DEAD.
REQ-039 Byte write 0x55 @0x11 over REQ-038 data, then word read @0x10 -> 0xDEAD55EF.
REQ-040 Word write @0x12 (misaligned) -> fault=1 next cycle, word @0x10 unchanged; half read @0x11 -> data_out=0, fault=1.
REQ-041 Write @MEM_BYTES (0x1000) -> no RAM change, fault=1; word read @0xFFC after write 0x12345678 -> 0x12345678.
REQ-042 Assert rst mid-write of 0xAAAAAAAA @0x20 after earlier 0x11111111 there -> read after reset returns 0x11111111.
